// File: rtl/conv_ctrl_pkg.sv
// Shared types and default widths for the convolution tile controllers.
package conv_ctrl_pkg;

  localparam int unsigned M_WIDTH  = 10;
  localparam int unsigned C_WIDTH  = 10;
  localparam int unsigned NT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FINAL = 2'd3
  } sched_state_t;

  // Latched layer descriptor; tile counts are already mapped so that 0 reads as 1.
  typedef struct packed {
    logic [NT_WIDTH-1:0] m_tiles;
    logic [NT_WIDTH-1:0] c_tiles;
    logic [M_WIDTH-1:0]  m_step;
    logic [C_WIDTH-1:0]  c_step;
  } tile_cfg_t;

endpackage

// File: rtl/tile_loop_counter.sv
// Filter-outer / channel-inner tile loop with accumulated base addresses.
module tile_loop_counter
  import conv_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  advance,
  input  logic                  zero_bases,
  input  tile_cfg_t             cfg,
  output logic [M_WIDTH-1:0]    filter_base,
  output logic [C_WIDTH-1:0]    channel_base,
  output logic                  last,
  output logic [2*NT_WIDTH-1:0] tile_count
);

  logic [NT_WIDTH-1:0]   mi_q, mi_d;
  logic [NT_WIDTH-1:0]   ci_q, ci_d;
  logic [M_WIDTH-1:0]    fb_q, fb_d;
  logic [C_WIDTH-1:0]    cb_q, cb_d;
  logic [2*NT_WIDTH-1:0] tc_q, tc_d;
  logic                  ci_last, mi_last;

  // Tile counts are at least 1, so index+1 never wraps before matching.
  assign ci_last = (ci_q + 1'b1) == cfg.c_tiles;
  assign mi_last = (mi_q + 1'b1) == cfg.m_tiles;

  always_comb begin
    mi_d = mi_q;
    ci_d = ci_q;
    fb_d = fb_q;
    cb_d = cb_q;
    tc_d = tc_q;
    if (start) begin
      mi_d = '0;
      ci_d = '0;
      fb_d = '0;
      cb_d = '0;
      tc_d = '0;
    end else begin
      if (advance) begin
        tc_d = tc_q + 1'b1;
        if (!ci_last) begin
          ci_d = ci_q + 1'b1;
          cb_d = cb_q + cfg.c_step;
        end else if (!mi_last) begin
          ci_d = '0;
          cb_d = '0;
          mi_d = mi_q + 1'b1;
          fb_d = fb_q + cfg.m_step;
        end
      end
      if (zero_bases) begin
        fb_d = '0;
        cb_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mi_q <= '0;
      ci_q <= '0;
      fb_q <= '0;
      cb_q <= '0;
      tc_q <= '0;
    end else begin
      mi_q <= mi_d;
      ci_q <= ci_d;
      fb_q <= fb_d;
      cb_q <= cb_d;
      tc_q <= tc_d;
    end
  end

  assign filter_base  = fb_q;
  assign channel_base = cb_q;
  assign last         = ci_last && mi_last;
  assign tile_count   = tc_q;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer controller: walks the filter x channel tile grid, one generator run per tile.
module conv_tile_scheduler #(
  parameter int unsigned M_WIDTH  = conv_ctrl_pkg::M_WIDTH,
  parameter int unsigned C_WIDTH  = conv_ctrl_pkg::C_WIDTH,
  parameter int unsigned NT_WIDTH = conv_ctrl_pkg::NT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [NT_WIDTH-1:0]   cfg_m_tiles,
  input  logic [NT_WIDTH-1:0]   cfg_c_tiles,
  input  logic [M_WIDTH-1:0]    cfg_m_step,
  input  logic [C_WIDTH-1:0]    cfg_c_step,
  input  logic                  buf_almost_full,
  output logic                  gen_start,
  output logic                  gen_await,
  output logic [M_WIDTH-1:0]    gen_filter_base,
  output logic [C_WIDTH-1:0]    gen_channel_base,
  input  logic                  gen_done,
  output logic [2*NT_WIDTH-1:0] tile_count,
  output logic                  layer_done
);

  localparam logic [NT_WIDTH-1:0] OneTile = {{(NT_WIDTH-1){1'b0}}, 1'b1};

  conv_ctrl_pkg::sched_state_t state_q, state_d;
  conv_ctrl_pkg::tile_cfg_t    cfg_q, cfg_d;

  logic cfg_ready_q, cfg_ready_d;
  logic gen_start_q, gen_start_d;
  logic gen_await_q, gen_await_d;
  logic layer_done_q, layer_done_d;
  logic loop_start, loop_advance, loop_zero, loop_last;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    loop_start   = 1'b0;
    loop_advance = 1'b0;
    loop_zero    = 1'b0;
    unique case (state_q)
      conv_ctrl_pkg::IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          cfg_d.m_tiles = (cfg_m_tiles == '0) ? OneTile : cfg_m_tiles;
          cfg_d.c_tiles = (cfg_c_tiles == '0) ? OneTile : cfg_c_tiles;
          cfg_d.m_step  = cfg_m_step;
          cfg_d.c_step  = cfg_c_step;
          loop_start    = 1'b1;
          state_d       = conv_ctrl_pkg::ISSUE;
        end
      end
      conv_ctrl_pkg::ISSUE: state_d = conv_ctrl_pkg::WAIT;
      conv_ctrl_pkg::WAIT: begin
        if (gen_done) begin
          loop_advance = 1'b1;
          state_d      = loop_last ? conv_ctrl_pkg::FINAL : conv_ctrl_pkg::ISSUE;
        end
      end
      conv_ctrl_pkg::FINAL: begin
        loop_zero = 1'b1;
        state_d   = conv_ctrl_pkg::IDLE;
      end
      default: state_d = conv_ctrl_pkg::IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_comb begin
    cfg_ready_d  = state_d == conv_ctrl_pkg::IDLE;
    gen_start_d  = state_d == conv_ctrl_pkg::ISSUE;
    layer_done_d = state_d == conv_ctrl_pkg::FINAL;
    gen_await_d  = buf_almost_full && (state_d != conv_ctrl_pkg::IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= conv_ctrl_pkg::IDLE;
      cfg_q        <= '0;
      cfg_ready_q  <= 1'b1;
      gen_start_q  <= 1'b0;
      gen_await_q  <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      cfg_ready_q  <= cfg_ready_d;
      gen_start_q  <= gen_start_d;
      gen_await_q  <= gen_await_d;
      layer_done_q <= layer_done_d;
    end
  end

  tile_loop_counter u_loop (
    .clk          (clk),
    .reset        (reset),
    .start        (loop_start),
    .advance      (loop_advance),
    .zero_bases   (loop_zero),
    .cfg          (cfg_d),
    .filter_base  (gen_filter_base),
    .channel_base (gen_channel_base),
    .last         (loop_last),
    .tile_count   (tile_count)
  );

  assign cfg_ready  = cfg_ready_q;
  assign gen_start  = gen_start_q;
  assign gen_await  = gen_await_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Randomized bench: acts as the filter generator and checks against a grid model.
module tb_conv_tile_scheduler;

  localparam int MW  = 10;
  localparam int CW  = 10;
  localparam int NTW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [NTW-1:0] cfg_m_tiles;
  logic [NTW-1:0] cfg_c_tiles;
  logic [MW-1:0]  cfg_m_step;
  logic [CW-1:0]  cfg_c_step;
  logic           buf_almost_full;
  logic           gen_start;
  logic           gen_await;
  logic [MW-1:0]  gen_filter_base;
  logic [CW-1:0]  gen_channel_base;
  logic           gen_done;
  logic [2*NTW-1:0] tile_count;
  logic           layer_done;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        buf_prev;

  always #5 clk = ~clk;

  conv_tile_scheduler #(
    .M_WIDTH  (MW),
    .C_WIDTH  (CW),
    .NT_WIDTH (NTW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_m_tiles      (cfg_m_tiles),
    .cfg_c_tiles      (cfg_c_tiles),
    .cfg_m_step       (cfg_m_step),
    .cfg_c_step       (cfg_c_step),
    .buf_almost_full  (buf_almost_full),
    .gen_start        (gen_start),
    .gen_await        (gen_await),
    .gen_filter_base  (gen_filter_base),
    .gen_channel_base (gen_channel_base),
    .gen_done         (gen_done),
    .tile_count       (tile_count),
    .layer_done       (layer_done)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Checks await for the current cycle, drives fresh back-pressure, then moves to next negedge.
  task automatic cycle(input bit idle_now);
    check_eq("gen_await", gen_await, (buf_prev && !idle_now) ? 1 : 0);
    buf_almost_full = 1'($urandom_range(0, 1));
    buf_prev        = buf_almost_full;
    @(negedge clk);
  endtask

  task automatic junk_cfg();
    cfg_valid   = 1'($urandom_range(0, 1));
    cfg_m_tiles = NTW'($urandom);
    cfg_c_tiles = NTW'($urandom);
    cfg_m_step  = MW'($urandom);
    cfg_c_step  = CW'($urandom);
  endtask

  task automatic run_layer(input int m, input int c, input int ms, input int cs,
                           input int min_d, input int max_d, input int abort_tile);
    int me, ce, n;
    me = (m == 0) ? 1 : m;
    ce = (c == 0) ? 1 : c;
    n  = me * ce;
    check_eq("idle_ready", cfg_ready, 1);
    check_eq("idle_start", gen_start, 0);
    cfg_valid   = 1'b1;
    cfg_m_tiles = NTW'(m);
    cfg_c_tiles = NTW'(c);
    cfg_m_step  = MW'(ms);
    cfg_c_step  = CW'(cs);
    gen_done    = 1'($urandom_range(0, 1));
    cycle(1);
    for (int t = 0; t < n; t++) begin
      int mi, ci, d;
      int unsigned efb, ecb;
      mi  = t / ce;
      ci  = t % ce;
      efb = (mi * ms) % (1 << MW);
      ecb = (ci * cs) % (1 << CW);
      check_eq("issue_start", gen_start, 1);
      check_eq("issue_fbase", gen_filter_base, efb);
      check_eq("issue_cbase", gen_channel_base, ecb);
      check_eq("issue_count", tile_count, t);
      check_eq("issue_ready", cfg_ready, 0);
      check_eq("issue_ldone", layer_done, 0);
      gen_done = 1'($urandom_range(0, 1));
      junk_cfg();
      cycle(0);
      if (t == abort_tile) begin
        gen_done  = 1'b0;
        cfg_valid = 1'b0;
        reset     = 1'b1;
        cycle(0);
        reset = 1'b0;
        check_eq("rst_start", gen_start, 0);
        check_eq("rst_ldone", layer_done, 0);
        check_eq("rst_count", tile_count, 0);
        check_eq("rst_fbase", gen_filter_base, 0);
        check_eq("rst_cbase", gen_channel_base, 0);
        check_eq("rst_await", gen_await, 0);
        check_eq("rst_ready", cfg_ready, 1);
        for (int k = 0; k < 4; k++) begin
          gen_done = 1'($urandom_range(0, 1));
          cycle(1);
          check_eq("rst_nostart", gen_start, 0);
          check_eq("rst_hold_cnt", tile_count, 0);
        end
        gen_done = 1'b0;
        return;
      end
      d = $urandom_range(min_d, max_d);
      for (int k = 0; k < d; k++) begin
        check_eq("wait_start", gen_start, 0);
        check_eq("wait_fbase", gen_filter_base, efb);
        check_eq("wait_cbase", gen_channel_base, ecb);
        check_eq("wait_ready", cfg_ready, 0);
        gen_done = 1'b0;
        junk_cfg();
        cycle(0);
      end
      check_eq("done_start", gen_start, 0);
      check_eq("done_count", tile_count, t);
      gen_done  = 1'b1;
      cfg_valid = 1'b0;
      cycle(0);
      gen_done = 1'b0;
    end
    check_eq("final_ldone", layer_done, 1);
    check_eq("final_count", tile_count, n);
    check_eq("final_start", gen_start, 0);
    check_eq("final_ready", cfg_ready, 0);
    cycle(0);
    check_eq("post_ldone", layer_done, 0);
    check_eq("post_fbase", gen_filter_base, 0);
    check_eq("post_cbase", gen_channel_base, 0);
    check_eq("post_ready", cfg_ready, 1);
    check_eq("post_count", tile_count, n);
  endtask

  initial begin
    reset           = 1'b1;
    cfg_valid       = 1'b0;
    cfg_m_tiles     = '0;
    cfg_c_tiles     = '0;
    cfg_m_step      = '0;
    cfg_c_step      = '0;
    buf_almost_full = 1'b0;
    buf_prev        = 1'b0;
    gen_done        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset_ready", cfg_ready, 1);
    check_eq("reset_start", gen_start, 0);
    check_eq("reset_await", gen_await, 0);
    check_eq("reset_ldone", layer_done, 0);
    check_eq("reset_count", tile_count, 0);
    check_eq("reset_fbase", gen_filter_base, 0);
    check_eq("reset_cbase", gen_channel_base, 0);
    for (int k = 0; k < 3; k++) begin
      gen_done = 1'($urandom_range(0, 1));
      cycle(1);
      check_eq("idle_spurious", gen_start, 0);
    end
    gen_done = 1'b0;

    run_layer(1, 1, 8, 4, 4, 4, -1);
    run_layer(2, 3, 16, 5, 0, 3, -1);
    run_layer(3, 1, 600, 7, 0, 2, -1);
    run_layer(0, 0, 33, 44, 0, 2, -1);
    run_layer(2, 3, 16, 5, 1, 3, 2);
    run_layer(2, 3, 16, 5, 0, 2, -1);
    for (int l = 0; l < 20; l++) begin
      run_layer($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 1023),
                $urandom_range(0, 1023), 0, 3, -1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        gen_done  = 1'($urandom_range(0, 1));
        cfg_valid = 1'b0;
        cycle(1);
      end
      gen_done = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
